cpu_fetch_seq: RTL

Parametrised fetch/decode sequencer for the multi-cycle CPU. It replaces the fixed 4-phase counter with a handshaked state machine that tolerates variable-latency instruction ROM, a back-pressuring execute stage, and N prioritised edge-triggered interrupt channels. It sits between the instruction ROM, the general-register file (read side) and the ALU/execute stage, and emits one decoded bundle per instruction.

---
 rtl/cpu_fetch_seq_pkg.sv | 44 ++++
 rtl/cpu_fetch_seq_if.sv | 47 ++++
 rtl/cpu_fetch_seq_irq_pend.sv | 55 +++++
 rtl/cpu_fetch_seq.sv | 134 +++++++++++++
 4 files changed

// File: rtl/cpu_fetch_seq_pkg.sv
// Shared types for the fetch/decode sequencer: FSM states, instruction field
// positions and the decoded-field bundle.
package cpu_fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_READ,
    ST_ISSUE,
    ST_WAIT_WB
  } fetch_state_e;

  localparam int OPCODE_LSB = 0;
  localparam int OPT_LSB    = 4;
  localparam int RD_LSB     = 8;
  localparam int RS1_LSB    = 12;
  localparam int RS2_LSB    = 16;
  localparam int IMM_LSB    = 20;

  typedef struct packed {
    logic [11:0] imm;
    logic [3:0]  rd;
    logic [3:0]  opt;
    logic [3:0]  opcode;
  } decode_bus_t;

  function automatic decode_bus_t decode(input logic [31:0] insn);
    decode_bus_t d;
    d.opcode = insn[OPCODE_LSB +: 4];
    d.opt    = insn[OPT_LSB +: 4];
    d.rd     = insn[RD_LSB +: 4];
    d.imm    = insn[IMM_LSB +: 12];
    return d;
  endfunction

  function automatic logic [3:0] rs1_of(input logic [31:0] insn);
    return insn[RS1_LSB +: 4];
  endfunction

  function automatic logic [3:0] rs2_of(input logic [31:0] insn);
    return insn[RS2_LSB +: 4];
  endfunction

endpackage

// File: rtl/cpu_fetch_seq_if.sv
// ROM fetch, decoded-bundle issue and writeback handshakes of the sequencer.
// master = sequencer side, slave = ROM / execute side.
interface cpu_fetch_seq_if #(
  parameter int PC_W = 11,
  parameter int XLEN = 32
) ();

  logic            rom_req;
  logic [PC_W-1:0] rom_addr;
  logic            rom_valid;
  logic [31:0]     rom_data;

  logic            de_valid;
  logic            de_ready;
  logic [PC_W-1:0] de_pc;
  logic [3:0]      de_opcode;
  logic [3:0]      de_opt;
  logic [3:0]      de_rd;
  logic [11:0]     de_imm;
  logic [XLEN-1:0] de_x_rs1;
  logic [XLEN-1:0] de_x_rs2;
  logic            de_irq_pend;
  logic [3:0]      de_irq_id;

  logic            wb_valid;
  logic [PC_W-1:0] wb_next_pc;
  logic            wb_irq_take;

  modport master (
    output rom_req, rom_addr,
    input  rom_valid, rom_data,
    output de_valid, de_pc, de_opcode, de_opt, de_rd, de_imm,
    output de_x_rs1, de_x_rs2, de_irq_pend, de_irq_id,
    input  de_ready,
    input  wb_valid, wb_next_pc, wb_irq_take
  );

  modport slave (
    input  rom_req, rom_addr,
    output rom_valid, rom_data,
    input  de_valid, de_pc, de_opcode, de_opt, de_rd, de_imm,
    input  de_x_rs1, de_x_rs2, de_irq_pend, de_irq_id,
    output de_ready,
    output wb_valid, wb_next_pc, wb_irq_take
  );

endinterface

// File: rtl/cpu_fetch_seq_irq_pend.sv
// Rising-edge interrupt capture with a pending register, lowest-index-first
// priority encoder and a one-cycle registered acknowledge.
module cpu_fetch_seq_irq_pend #(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             clr_i,
  input  logic [3:0]       clr_id_i,
  output logic             pend_any_o,
  output logic [3:0]       pend_id_o,
  output logic [N_IRQ-1:0] irq_ack_o
);

  logic [N_IRQ-1:0] irq_prev_q;
  logic [N_IRQ-1:0] pend_q;
  logic [N_IRQ-1:0] pend_d;
  logic [N_IRQ-1:0] clr_mask;
  logic [N_IRQ-1:0] irq_ack_q;

  // Set is ORed in after the clear, so a fresh edge on a bit being acked keeps it pending.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    clr_mask = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr_mask[i] = clr_i && (clr_id_i == 4'(i));
    end
    pend_d = (pend_q & ~clr_mask) | (irq_i & ~irq_prev_q);
  end

  always_comb begin
    pend_id_o = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pend_q[i]) pend_id_o = 4'(i);
    end
  end

  assign pend_any_o = |pend_q;
  assign irq_ack_o  = irq_ack_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with nonblocking assignments only.
    if (reset) begin
      irq_prev_q <= '0;
      pend_q     <= '0;
      irq_ack_q  <= '0;
    end else begin
      irq_prev_q <= irq_i;
      pend_q     <= pend_d;
      irq_ack_q  <= clr_mask;
    end
  end

endmodule

// File: rtl/cpu_fetch_seq.sv
// Handshaked fetch/decode sequencer: fetches from a variable-latency ROM, reads
// the register file, issues one decoded bundle and waits for the next PC.
module cpu_fetch_seq
  import cpu_fetch_seq_pkg::*;
#(
  parameter int              PC_W     = 11,
  parameter int              XLEN     = 32,
  parameter int              N_IRQ    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_fetch_seq_if.master      bus,
  output logic [3:0]           rs1_idx,
  output logic [3:0]           rs2_idx,
  input  logic [XLEN-1:0]      x_rs1,
  input  logic [XLEN-1:0]      x_rs2,
  input  logic [N_IRQ-1:0]     irq,
  output logic [N_IRQ-1:0]     irq_ack,
  output logic [31:0]          instret
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic            rom_req_q;
  decode_bus_t     dec_q;
  logic [3:0]      rs1_idx_q;
  logic [3:0]      rs2_idx_q;
  logic            de_valid_q;
  decode_bus_t     de_bus_q;
  logic [PC_W-1:0] de_pc_q;
  logic [XLEN-1:0] de_x_rs1_q;
  logic [XLEN-1:0] de_x_rs2_q;
  logic            de_irq_pend_q;
  logic [3:0]      de_irq_id_q;
  logic [31:0]     instret_q;

  logic            pend_any;
  logic [3:0]      pend_id;
  logic            irq_take;

  // An interrupt is only retired if the issued bundle actually reported one.
  assign irq_take = (state_q == ST_WAIT_WB) && bus.wb_valid && bus.wb_irq_take && de_irq_pend_q;

  cpu_fetch_seq_irq_pend #(.N_IRQ(N_IRQ)) u_irq_pend (
    .clk        (clk),
    .reset      (reset),
    .irq_i      (irq),
    .clr_i      (irq_take),
    .clr_id_i   (de_irq_id_q),
    .pend_any_o (pend_any),
    .pend_id_o  (pend_id),
    .irq_ack_o  (irq_ack)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      rom_req_q     <= 1'b0;
      dec_q         <= '0;
      rs1_idx_q     <= '0;
      rs2_idx_q     <= '0;
      de_valid_q    <= 1'b0;
      de_bus_q      <= '0;
      de_pc_q       <= '0;
      de_x_rs1_q    <= '0;
      de_x_rs2_q    <= '0;
      de_irq_pend_q <= 1'b0;
      de_irq_id_q   <= '0;
      instret_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          rom_req_q <= 1'b1;
          state_q   <= ST_FETCH;
        end
        ST_FETCH: begin
          if (bus.rom_valid) begin
            dec_q     <= decode(bus.rom_data);
            rs1_idx_q <= rs1_of(bus.rom_data);
            rs2_idx_q <= rs2_of(bus.rom_data);
            rom_req_q <= 1'b0;
            state_q   <= ST_READ;
          end
        end
        ST_READ: begin
          de_bus_q      <= dec_q;
          de_pc_q       <= pc_q;
          de_x_rs1_q    <= x_rs1;
          de_x_rs2_q    <= x_rs2;
          de_irq_pend_q <= pend_any;
          de_irq_id_q   <= pend_id;
          rs1_idx_q     <= '0;
          rs2_idx_q     <= '0;
          de_valid_q    <= 1'b1;
          state_q       <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (bus.de_ready) begin
            de_valid_q <= 1'b0;
            state_q    <= ST_WAIT_WB;
          end
        end
        ST_WAIT_WB: begin
          if (bus.wb_valid) begin
            pc_q      <= bus.wb_next_pc;
            instret_q <= instret_q + 32'd1;
            rom_req_q <= 1'b1;
            state_q   <= ST_FETCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rom_req     = rom_req_q;
  assign bus.rom_addr    = pc_q;
  assign bus.de_valid    = de_valid_q;
  assign bus.de_pc       = de_pc_q;
  assign bus.de_opcode   = de_bus_q.opcode;
  assign bus.de_opt      = de_bus_q.opt;
  assign bus.de_rd       = de_bus_q.rd;
  assign bus.de_imm      = de_bus_q.imm;
  assign bus.de_x_rs1    = de_x_rs1_q;
  assign bus.de_x_rs2    = de_x_rs2_q;
  assign bus.de_irq_pend = de_irq_pend_q;
  assign bus.de_irq_id   = de_irq_id_q;
  assign rs1_idx         = rs1_idx_q;
  assign rs2_idx         = rs2_idx_q;
  assign instret         = instret_q;

endmodule
